// File: rtl/ahb_sram_mem_ctrl.sv
// rtl/ahb_sram_mem_ctrl.sv - AHB-Lite slave bridging to banked asynchronous SRAM
module ahb_sram_mem_ctrl #(
    parameter int ADDR_W     = 20,
    parameter int MEM_DATA_W = 16,
    parameter int NUM_CS     = 1,
    parameter int RD_WS      = 1,
    parameter int WR_WS      = 1
) (
    input  logic                    HCLK,
    input  logic                    HRESETN,
    input  logic                    HSEL,
    input  logic [ADDR_W-1:0]       HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [31:0]             HWDATA,
    input  logic                    HREADYIN,
    output logic [31:0]             HRDATA,
    output logic                    HREADY,
    output logic [1:0]              HRESP,
    output logic [ADDR_W-1:0]       MEMADDR,
    input  logic [MEM_DATA_W-1:0]   MEMDATA_I,
    output logic [MEM_DATA_W-1:0]   MEMDATA_O,
    output logic                    MEMDATA_OE,
    output logic [NUM_CS-1:0]       SRAMCSN,
    output logic                    SRAMOEN,
    output logic                    SRAMWEN,
    output logic [MEM_DATA_W/8-1:0] SRAMBYTEN
);
    localparam int BYTES   = MEM_DATA_W / 8;
    localparam int LANE_SH = $clog2(BYTES);
    localparam int BANK_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam logic [3:0] RD_CNT = 4'(RD_WS);
    localparam logic [3:0] WR_CNT = 4'(WR_WS);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, RDONE, ERR1, ERR2} state_t;
    state_t state, state_n;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              write_q;
    logic [BANK_W-1:0] bank_q;
    logic [1:0]        last_q;
    logic [1:0]        beat_q;
    logic [3:0]        cnt_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rbuf_q;

    logic              addr_bad, accept, last_beat, done_cyc, acc_end, beat_inc, cs_act;
    logic [3:0]        ws_cnt;
    logic [31:0]       wsrc, wshift, rd_merge;
    logic [BYTES-1:0]  wr_mask;
    logic [NUM_CS-1:0] csn_on;
    int                lane, nbytes, mask_i;
    logic              unused_htrans;

    assign unused_htrans = HTRANS[0];

    // Number of memory beats minus one for a legal AHB size
    function automatic logic [1:0] last_of(input logic [2:0] size);
        int nb, n;
        nb = 1 << size;
        n  = (nb > BYTES) ? nb / BYTES : 1;
        return 2'(n - 1);
    endfunction

    assign addr_bad  = (HSIZE > 3'd2) || (HSIZE == 3'd1 && HADDR[0]) ||
                       (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
    assign last_beat = (beat_q == last_q);
    assign done_cyc  = (state == RDONE) || (state == HOLD && last_beat);
    assign accept    = HSEL && HREADYIN && HTRANS[1] && (state == IDLE || done_cyc);
    assign ws_cnt    = write_q ? WR_CNT : RD_CNT;
    assign acc_end   = (cnt_q == ws_cnt);

    always_ff @(posedge HCLK) begin
        if (!HRESETN) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n    = state;
        beat_inc   = 1'b0;
        HREADY     = 1'b0;
        HRESP      = 2'b00;
        cs_act     = 1'b0;
        SRAMOEN    = 1'b1;
        SRAMWEN    = 1'b1;
        MEMDATA_OE = 1'b0;
        case (state)
            IDLE, RDONE: begin
                HREADY  = 1'b1;
                state_n = accept ? (addr_bad ? ERR1 : SETUP) : IDLE;
            end
            SETUP: begin
                cs_act     = 1'b1;
                MEMDATA_OE = write_q;
                state_n    = ACCESS;
            end
            ACCESS: begin
                cs_act     = 1'b1;
                MEMDATA_OE = write_q;
                SRAMOEN    = write_q;
                SRAMWEN    = !write_q;
                if (acc_end) begin
                    if (write_q) begin
                        state_n = HOLD;
                    end else if (last_beat) begin
                        state_n = RDONE;
                    end else begin
                        state_n  = SETUP;
                        beat_inc = 1'b1;
                    end
                end
            end
            HOLD: begin
                cs_act     = 1'b1;
                MEMDATA_OE = 1'b1;
                HREADY     = last_beat;
                if (!last_beat) begin
                    state_n  = SETUP;
                    beat_inc = 1'b1;
                end else begin
                    state_n = accept ? (addr_bad ? ERR1 : SETUP) : IDLE;
                end
            end
            ERR1: begin
                HRESP   = 2'b01;
                state_n = ERR2;
            end
            ERR2: begin
                HREADY  = 1'b1;
                HRESP   = 2'b01;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Lane of the 32-bit AHB bus that the current memory beat maps onto
    always_comb begin
        lane     = int'(addr_q[1:0]) / BYTES + int'(beat_q);
        nbytes   = 1 << size_q;
        mask_i   = ((1 << nbytes) - 1) << (int'(addr_q[1:0]) % BYTES);
        wr_mask  = (nbytes >= BYTES) ? '1 : mask_i[BYTES-1:0];
        wsrc     = (state == SETUP && beat_q == 2'd0) ? HWDATA : wdata_q;
        wshift   = wsrc >> (lane * MEM_DATA_W);
        rd_merge = rbuf_q | (32'(MEMDATA_I) << (lane * MEM_DATA_W));
        csn_on   = cs_act ? (NUM_CS'(1) << bank_q) : '0;
    end

    assign MEMADDR   = (addr_q >> LANE_SH) + ADDR_W'(beat_q);
    assign MEMDATA_O = MEMDATA_OE ? wshift[MEM_DATA_W-1:0] : '0;
    assign SRAMCSN   = ~csn_on;
    assign SRAMBYTEN = cs_act ? (write_q ? ~wr_mask : '0) : '1;

    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            bank_q  <= '0;
            last_q  <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            HRDATA  <= '0;
        end else begin
            if (accept) begin
                addr_q  <= HADDR;
                size_q  <= HSIZE[1:0];
                write_q <= HWRITE;
                bank_q  <= (NUM_CS > 1) ? HADDR[ADDR_W-1 -: BANK_W] : '0;
                last_q  <= last_of(HSIZE);
                beat_q  <= '0;
                rbuf_q  <= '0;
            end else if (beat_inc) begin
                beat_q <= beat_q + 2'd1;
            end
            if (state == SETUP) begin
                cnt_q <= '0;
                if (write_q && beat_q == 2'd0) wdata_q <= HWDATA;
            end else if (state == ACCESS) begin
                cnt_q <= cnt_q + 4'd1;
                if (acc_end && !write_q) begin
                    rbuf_q <= rd_merge;
                    if (last_beat) HRDATA <= rd_merge;
                end
            end
        end
    end
endmodule
